regfile_sb: RTL and testbench

Parametrised multi-read-port register file with an integrated scoreboard, the next-generation replacement for the fixed 32x32 two-read-port register file in the CPU datapath. It holds NREGS architectural registers of XLEN bits, serves NRD combinational read ports, and accepts one writeback per cycle. A pending-bit scoreboard marks destinations of in-flight instructions, so decode can stall on RAW hazards without a separate hazard unit. Register 0 is optionally hardwired to zero.

---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_rdport.sv | 44 ++++
 rtl/regfile_sb.sv | 93 +++++++++
 tb/tb_regfile_sb.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the regfile_sb register file and its read ports.
package regfile_pkg;

    localparam int DEF_XLEN     = 32;
    localparam int DEF_NREGS    = 32;
    localparam int DEF_NRD      = 2;
    localparam bit DEF_ZERO_REG = 1'b1;

    function automatic int addr_width(input int nregs);
        return (nregs < 2) ? 1 : $clog2(nregs);
    endfunction

endpackage

// File: rtl/regfile_rdport.sv
// One combinational read port: storage mux, register-0 forcing and, with
// REGFILE_BYPASS_EN defined, a same-cycle writeback bypass.
module regfile_rdport #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int AW       = 5,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic [AW-1:0]         addr,
    input  logic [NREGS*XLEN-1:0] mem_flat,
    input  logic [NREGS-1:0]      busy_vec,
`ifdef REGFILE_BYPASS_EN
    input  logic                  rd_we,
    input  logic [AW-1:0]         rd_addr,
    input  logic [XLEN-1:0]       rd_wdata,
    input  logic                  iss_en,
    input  logic [AW-1:0]         iss_addr,
    input  logic                  flush,
`endif
    output logic [XLEN-1:0]       data,
    output logic                  busy
);

    logic is_zero;
    assign is_zero = ZERO_REG && (addr == '0);

    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        data = mem_flat[int'(addr)*XLEN +: XLEN];
        busy = busy_vec[addr];
`ifdef REGFILE_BYPASS_EN
        // The in-flight writeback wins over storage; a same-cycle issue re-marks it pending.
        if (rd_we && (rd_addr == addr)) begin
            data = rd_wdata;
            busy = iss_en && !flush && (iss_addr == addr);
        end
`endif
        if (is_zero) begin
            data = '0;
            busy = 1'b0;
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Multi-read-port register file with pending-bit scoreboard.
// Optional same-cycle write bypass on the read ports: define REGFILE_BYPASS_EN.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter  int XLEN     = DEF_XLEN,
    parameter  int NREGS    = DEF_NREGS,
    parameter  int NRD      = DEF_NRD,
    parameter  bit ZERO_REG = DEF_ZERO_REG,
    localparam int AW       = addr_width(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rs_addr,
    output logic [NRD*XLEN-1:0] rs_data,
    output logic [NRD-1:0]      rs_busy,
    input  logic                rd_we,
    input  logic [AW-1:0]       rd_addr,
    input  logic [XLEN-1:0]     rd_wdata,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_addr,
    input  logic                flush,
    output logic [AW:0]         busy_cnt
);

    logic [XLEN-1:0]       mem [NREGS];
    logic [NREGS-1:0]      busy;
    logic [NREGS-1:0]      busy_nxt;
    logic [AW:0]           cnt_nxt;
    logic [NREGS*XLEN-1:0] mem_flat;
    logic                  wr_ok;
    logic                  iss_ok;

    assign wr_ok  = rd_we && !(ZERO_REG && (rd_addr == '0));
    assign iss_ok = iss_en && !flush && !(ZERO_REG && (iss_addr == '0));

    // Clear before set so a same-cycle issue to the written register ends pending.
    always_comb begin
        busy_nxt = busy;
        if (flush) begin
            busy_nxt = '0;
        end else begin
            if (wr_ok)  busy_nxt[rd_addr]  = 1'b0;
            if (iss_ok) busy_nxt[iss_addr] = 1'b1;
        end
        cnt_nxt = '0;
        for (int i = 0; i < NREGS; i++) begin
            cnt_nxt = cnt_nxt + (AW+1)'(busy_nxt[i]);
        end
    end

    // NOTE: the storage array is reset too, because reads of any register must return zero after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) mem[i] <= '0;
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            if (wr_ok) mem[rd_addr] <= rd_wdata;
            busy     <= busy_nxt;
            busy_cnt <= cnt_nxt;
        end
    end

    always_comb begin
        mem_flat = '0;
        for (int i = 0; i < NREGS; i++) mem_flat[i*XLEN +: XLEN] = mem[i];
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        regfile_rdport #(
            .XLEN     (XLEN),
            .NREGS    (NREGS),
            .AW       (AW),
            .ZERO_REG (ZERO_REG)
        ) u_rdport (
            .addr     (rs_addr[k*AW +: AW]),
            .mem_flat (mem_flat),
            .busy_vec (busy),
`ifdef REGFILE_BYPASS_EN
            .rd_we    (rd_we),
            .rd_addr  (rd_addr),
            .rd_wdata (rd_wdata),
            .iss_en   (iss_en),
            .iss_addr (iss_addr),
            .flush    (flush),
`endif
            .data     (rs_data[k*XLEN +: XLEN]),
            .busy     (rs_busy[k])
        );
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: vector table with scoreboard queue plus
// hand sequences for bypass timing and asynchronous reset.
module tb_regfile_sb;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int AW    = 5;

    logic                clk;
    logic                rst;
    logic [NRD*AW-1:0]   rs_addr;
    logic [NRD*XLEN-1:0] rs_data;
    logic [NRD-1:0]      rs_busy;
    logic                rd_we;
    logic [AW-1:0]       rd_addr;
    logic [XLEN-1:0]     rd_wdata;
    logic                iss_en;
    logic [AW-1:0]       iss_addr;
    logic                flush;
    logic [AW:0]         busy_cnt;

    regfile_sb #(
        .XLEN     (XLEN),
        .NREGS    (NREGS),
        .NRD      (NRD),
        .ZERO_REG (1'b1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rs_addr  (rs_addr),
        .rs_data  (rs_data),
        .rs_busy  (rs_busy),
        .rd_we    (rd_we),
        .rd_addr  (rd_addr),
        .rd_wdata (rd_wdata),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .flush    (flush),
        .busy_cnt (busy_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic            we;
        logic [AW-1:0]   wa;
        logic [XLEN-1:0] wd;
        logic            iss;
        logic [AW-1:0]   ia;
        logic            fl;
        logic [AW-1:0]   ra0;
        logic [AW-1:0]   ra1;
        logic [XLEN-1:0] d0;
        logic [XLEN-1:0] d1;
        logic            b0;
        logic            b1;
        logic [AW:0]     cnt;
    } vec_t;

    typedef struct {
        logic [XLEN-1:0] d0;
        logic [XLEN-1:0] d1;
        logic            b0;
        logic            b1;
        logic [AW:0]     cnt;
    } exp_t;

    vec_t vecs [14];
    exp_t exp_q [$];
    int   n_vec  = 0;
    int   n_miss = 0;

    function automatic vec_t mk(input logic we, input int wa, input logic [XLEN-1:0] wd,
                                input logic iss, input int ia, input logic fl,
                                input int ra0, input int ra1,
                                input logic [XLEN-1:0] d0, input logic [XLEN-1:0] d1,
                                input logic b0, input logic b1, input int cnt);
        vec_t v;
        v.we  = we;         v.wa  = AW'(wa);    v.wd = wd;
        v.iss = iss;        v.ia  = AW'(ia);    v.fl = fl;
        v.ra0 = AW'(ra0);   v.ra1 = AW'(ra1);
        v.d0  = d0;         v.d1  = d1;
        v.b0  = b0;         v.b1  = b1;         v.cnt = (AW+1)'(cnt);
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        rd_we  = 1'b0;
        iss_en = 1'b0;
        flush  = 1'b0;
    endtask

    task automatic read_pair(input int a0, input int a1);
        rs_addr = {AW'(a1), AW'(a0)};
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;

        //            we wa  wd            iss ia fl ra0 ra1 d0            d1            b0 b1 cnt
        vecs[0]  = mk(1, 0,  32'hFFFF_FFFF, 0, 0, 0, 0,  0,  32'h0,        32'h0,        0, 0, 0);
        vecs[1]  = mk(1, 5,  32'hABCA_ABCA, 0, 0, 0, 5,  0,  32'hABCA_ABCA, 32'h0,       0, 0, 0);
        vecs[2]  = mk(0, 0,  32'h0,         1, 7, 0, 7,  5,  32'h0,        32'hABCA_ABCA, 1, 0, 1);
        vecs[3]  = mk(1, 7,  32'h1111_1111, 0, 0, 0, 7,  7,  32'h1111_1111, 32'h1111_1111, 0, 0, 0);
        vecs[4]  = mk(1, 9,  32'h9999_9999, 1, 9, 0, 9,  7,  32'h9999_9999, 32'h1111_1111, 1, 0, 1);
        vecs[5]  = mk(0, 0,  32'h0,         1, 1, 0, 1,  9,  32'h0,        32'h9999_9999, 1, 1, 2);
        vecs[6]  = mk(0, 0,  32'h0,         1, 2, 0, 2,  3,  32'h0,        32'h0,        1, 0, 3);
        vecs[7]  = mk(0, 0,  32'h0,         1, 3, 0, 3,  1,  32'h0,        32'h0,        1, 1, 4);
        vecs[8]  = mk(1, 4,  32'h2222_2222, 1, 6, 1, 4,  6,  32'h2222_2222, 32'h0,       0, 0, 0);
        vecs[9]  = mk(0, 0,  32'h0,         1, 0, 0, 0,  9,  32'h0,        32'h9999_9999, 0, 0, 0);
        vecs[10] = mk(0, 0,  32'h0,         1, 7, 0, 7,  9,  32'h1111_1111, 32'h9999_9999, 1, 0, 1);
        vecs[11] = mk(0, 0,  32'h0,         1, 7, 0, 7,  9,  32'h1111_1111, 32'h9999_9999, 1, 0, 1);
        vecs[12] = mk(1, 3,  32'hBABA_BABA, 0, 0, 0, 3,  7,  32'hBABA_BABA, 32'h1111_1111, 0, 1, 1);
        vecs[13] = mk(0, 0,  32'h0,         1, 3, 0, 3,  7,  32'hBABA_BABA, 32'h1111_1111, 1, 1, 2);

        rst = 1'b0;
        idle();
        rd_addr  = '0;
        rd_wdata = '0;
        iss_addr = '0;
        read_pair(5, 9);
        repeat (2) @(posedge clk);
        #1;
        check("in_reset_data0", rs_data[31:0], 32'h0);
        check("in_reset_cnt", 32'(busy_cnt), 32'h0);

        @(negedge clk);
        rst = 1'b1;
        for (int a = 0; a < NREGS; a++) begin
            read_pair(a, NREGS - 1 - a);
            #1;
            check($sformatf("rst_data0[%0d]", a), rs_data[31:0], 32'h0);
            check($sformatf("rst_data1[%0d]", a), rs_data[63:32], 32'h0);
            check($sformatf("rst_busy[%0d]", a), 32'(rs_busy), 32'h0);
        end
        check("rst_cnt", 32'(busy_cnt), 32'h0);

        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            rd_we    = vecs[i].we;
            rd_addr  = vecs[i].wa;
            rd_wdata = vecs[i].wd;
            iss_en   = vecs[i].iss;
            iss_addr = vecs[i].ia;
            flush    = vecs[i].fl;
            read_pair(int'(vecs[i].ra0), int'(vecs[i].ra1));
            exp_q.push_back('{vecs[i].d0, vecs[i].d1, vecs[i].b0, vecs[i].b1, vecs[i].cnt});
            @(posedge clk);
            #1;
            idle();
            #1;
            e = exp_q.pop_front();
            check($sformatf("v%0d_data0", i), rs_data[31:0], e.d0);
            check($sformatf("v%0d_data1", i), rs_data[63:32], e.d1);
            check($sformatf("v%0d_busy0", i), 32'(rs_busy[0]), 32'(e.b0));
            check($sformatf("v%0d_busy1", i), 32'(rs_busy[1]), 32'(e.b1));
            check($sformatf("v%0d_cnt", i), 32'(busy_cnt), 32'(e.cnt));
        end

        // Write-to-read latency on register 5, observed before the edge.
        @(negedge clk);
        rd_we    = 1'b1;
        rd_addr  = 5'd5;
        rd_wdata = 32'h5555_5555;
        read_pair(5, 9);
        #1;
`ifdef REGFILE_BYPASS_EN
        check("byp_same_cycle_data", rs_data[31:0], 32'h5555_5555);
`else
        check("nobyp_same_cycle_data", rs_data[31:0], 32'hABCA_ABCA);
`endif
        check("byp_same_cycle_busy", 32'(rs_busy[0]), 32'h0);
        @(posedge clk);
        #1;
        idle();
        #1;
        check("byp_next_cycle_data", rs_data[31:0], 32'h5555_5555);
        check("byp_next_cycle_cnt", 32'(busy_cnt), 32'h2);

        // Asynchronous reset mid-cycle with reg 3 = BABA_BABA and busy.
        @(posedge clk);
        #2;
        read_pair(3, 7);
        #1;
        check("pre_arst_data0", rs_data[31:0], 32'hBABA_BABA);
        check("pre_arst_busy0", 32'(rs_busy[0]), 32'h1);
        rst = 1'b0;
        #1;
        check("arst_data0", rs_data[31:0], 32'h0);
        check("arst_data1", rs_data[63:32], 32'h0);
        check("arst_busy", 32'(rs_busy), 32'h0);
        check("arst_cnt", 32'(busy_cnt), 32'h0);

        @(negedge clk);
        rd_we    = 1'b1;
        rd_addr  = 5'd3;
        rd_wdata = 32'hDEAD_BEEF;
        iss_en   = 1'b1;
        iss_addr = 5'd3;
        @(posedge clk);
        #1;
        idle();
        #1;
        check("held_rst_data0", rs_data[31:0], 32'h0);
        check("held_rst_cnt", 32'(busy_cnt), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("post_rst_data0", rs_data[31:0], 32'h0);
        check("post_rst_busy", 32'(rs_busy), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
